// File: rtl/rot_pixel_packer.sv
// rot_pixel_packer: packs the rotated 8-bit pixel stream into 32-bit words behind a small
// word FIFO, with sticky row/frame geometry error flags (the adapter cannot be stalled).
module rot_pixel_packer #(
   parameter int IMG_W      = 256,
   parameter int IMG_H      = 256,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     pix_valid,
   input  logic [7:0]               pix_data,
   input  logic                     pix_jump,
   input  logic                     pix_done,
   output logic                     word_valid,
   input  logic                     word_ready,
   output logic [31:0]              word_data,
   output logic                     word_last,
   output logic [$clog2(IMG_H)-1:0] row_idx,
   output logic                     frame_done,
   output logic                     err_overflow,
   output logic                     err_row_len,
   output logic                     err_frame_len
);
   localparam int CW = $clog2(IMG_W + 1);
   localparam int RW = $clog2(IMG_H);
   localparam int TW = $clog2(IMG_W * IMG_H + 1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] ROW_END   = CW'(IMG_W);
   localparam logic [RW-1:0] ROW_MAX   = RW'(IMG_H - 1);
   localparam logic [TW-1:0] FRAME_END = TW'(IMG_W * IMG_H);
   localparam logic [AW:0]   FULL      = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] col_q, col_d, col_b, col_n;
   logic [RW-1:0] row_q, row_d;
   logic [TW-1:0] total_q, total_d, total_n;
   logic [31:0]   pack_q, pack_d, pack_n;
   logic          fin_q, fin_d, done_q, done_d;
   logic          eo_q, eo_d, er_q, er_d, ef_q, ef_d;
   logic [32:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0] wptr_q, rptr_q, wlast;
   logic [AW:0]   cnt_q;
   logic          push, pop, wr, drop, mark, mark_ok;
   logic [32:0]   push_word;
   logic          new_row, flush, full_word, complete, end_f, tail;
   logic [1:0]    lane;

   assign new_row   = pix_jump || col_q == ROW_END;
   assign flush     = new_row && col_q[1:0] != 2'd0;
   assign col_b     = new_row ? '0 : col_q;
   assign lane      = col_b[1:0];
   assign pack_n    = (new_row ? 32'd0 : pack_q) | (32'(pix_data) << {lane, 3'b000});
   assign col_n     = col_b + CW'(1);
   assign total_n   = total_q + TW'(1);
   assign complete  = total_n == FRAME_END;
   assign end_f     = complete || pix_done;
   assign tail      = end_f && col_n[1:0] != 2'd0;
   assign full_word = lane == 2'd3;

   assign pop     = cnt_q != '0 && word_ready;
   assign wr      = push && (cnt_q != FULL || pop);
   assign drop    = push && !wr;
   assign wlast   = wptr_q - AW'(1);
   assign mark_ok = mark && cnt_q != '0 && !(cnt_q == (AW + 1)'(1) && pop);

   always_comb begin
      state_d   = state_q;
      col_d     = col_q;
      row_d     = row_q;
      total_d   = total_q;
      pack_d    = pack_q;
      fin_d     = fin_q;
      done_d    = 1'b0;
      eo_d      = eo_q;
      er_d      = er_q;
      ef_d      = ef_q;
      push      = 1'b0;
      push_word = {1'b0, pack_n};
      mark      = 1'b0;
      case (state_q)
         IDLE: if (pix_valid && pix_jump) begin
            state_d = RUN;
            eo_d    = 1'b0;
            er_d    = 1'b0;
            ef_d    = 1'b0;
            pack_d  = {24'd0, pix_data};
            col_d   = CW'(1);
            row_d   = '0;
            total_d = TW'(1);
         end
         RUN: if (fin_q) begin
            push      = 1'b1;
            push_word = {1'b1, pack_q};
            fin_d     = 1'b0;
            state_d   = DRAIN;
         end else if (pix_valid) begin
            er_d    = er_q | (new_row && !(pix_jump && col_q == ROW_END));
            ef_d    = ef_q | (pix_done && !complete);
            row_d   = new_row && row_q != ROW_MAX ? row_q + RW'(1) : row_q;
            col_d   = col_n;
            total_d = total_n;
            pack_d  = full_word || (tail && !flush) ? 32'd0 : pack_n;
            // A flush and a frame-ending partial word collide: emit the tail one cycle later
            if (flush) begin
               push      = 1'b1;
               push_word = {1'b0, pack_q};
               fin_d     = tail;
            end else if (full_word || tail) begin
               push      = 1'b1;
               push_word = {end_f, pack_n};
            end
            if (end_f && !flush) state_d = DRAIN;
         end else if (pix_done) begin
            ef_d      = 1'b1;
            push      = col_q[1:0] != 2'd0;
            push_word = {1'b1, pack_q};
            mark      = col_q[1:0] == 2'd0;
            state_d   = DRAIN;
         end
         DRAIN: if (cnt_q == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         col_q   <= '0;
         row_q   <= '0;
         total_q <= '0;
         pack_q  <= '0;
         fin_q   <= 1'b0;
         done_q  <= 1'b0;
         eo_q    <= 1'b0;
         er_q    <= 1'b0;
         ef_q    <= 1'b0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         cnt_q   <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         total_q <= total_d;
         pack_q  <= pack_d;
         fin_q   <= fin_d;
         done_q  <= done_d;
         eo_q    <= eo_d || drop;
         er_q    <= er_d;
         ef_q    <= ef_d;
         if (wr) mem_q[wptr_q] <= push_word;
         if (mark_ok) mem_q[wlast][32] <= 1'b1;
         wptr_q  <= wptr_q + AW'(wr);
         rptr_q  <= rptr_q + AW'(pop);
         cnt_q   <= cnt_q + (AW + 1)'(wr) - (AW + 1)'(pop);
      end
   end

   assign word_valid              = cnt_q != '0;
   assign {word_last, word_data}  = word_valid ? mem_q[rptr_q] : 33'd0;
   assign row_idx                 = row_q;
   assign frame_done              = done_q;
   assign err_overflow            = eo_q;
   assign err_row_len             = er_q;
   assign err_frame_len           = ef_q;
endmodule

// File: doc/rot_pixel_packer.md
Name: rot_pixel_packer

Overview:
- Sits directly downstream of the rotation adapter and consumes its rotated 8-bit pixel stream, row-jump marker and done flag.
- Packs 4 pixels into 32-bit words and buffers them in a small word FIFO for a valid/ready memory or AXI-style writer.
- Checks row and frame geometry, flagging sticky errors because the adapter cannot be back-pressured.

Parameters:
- IMG_W, 256, pixels per output row; must be a multiple of 4.
- IMG_H, 256, rows per frame.
- FIFO_DEPTH, 4, word FIFO entries; power of 2, at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- pix_valid  in  1  pixel present on pix_data this cycle.
- pix_data  in  8  rotated pixel (adapter data_out).
- pix_jump  in  1  qualified by pix_valid: this pixel is the first of an output row (adapter jump_out).
- pix_done  in  1  adapter output_done: the frame stream has ended.
- word_valid  out  1  FIFO head word valid.
- word_ready  in  1  downstream accepts the word when valid and ready are both 1.
- word_data  out  32  packed pixels; first pixel in [7:0], fourth in [31:24].
- word_last  out  1  head word is the final word of the frame.
- row_idx  out  clog2(IMG_H)  current output row being packed.
- frame_done  out  1  one-cycle pulse when the frame has fully drained.
- err_overflow  out  1  sticky: a completed word was dropped because the FIFO was full.
- err_row_len  out  1  sticky: a row did not contain exactly IMG_W pixels.
- err_frame_len  out  1  sticky: pix_done arrived before IMG_W*IMG_H pixels.

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs are 0; FIFO is empty; all counters are 0; state is IDLE.
  - Reset mid-frame discards everything, including words not yet accepted.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - pix_valid with pix_jump=0 is ignored.
  - pix_valid with pix_jump=1 clears all error flags, accepts that pixel as col 0 of row 0, and moves to RUN.
- RUN, every pixel with pix_valid=1:
  - The pixel shifts into the packing register at lane col%4.
  - On lane 3, the word is pushed to the FIFO on the same edge; it appears on word_valid one cycle after the 4th pixel is sampled.
  - If the FIFO is full at push, the word is dropped, err_overflow is set, and counting continues.
- Row rules:
  - pix_jump with col != IMG_W, other than the first pixel of the frame, sets err_row_len; row_idx increments and col resets.
  - A partial packing register is flushed first as a zero-padded word.
  - A pixel without pix_jump when col == IMG_W sets err_row_len; the pixel is treated as an implicit new row.
  - Words never span rows.
- End of frame:
  - When the total pixel count reaches IMG_W*IMG_H, the pushed word carries word_last=1 and the state moves to DRAIN; later pixels are ignored.
  - pix_done in RUN before the full count sets err_frame_len, flushes any partial word zero-padded with last=1 (or marks the last pushed word if no partial word exists), and moves to DRAIN.
  - pix_done while pix_valid=1 in the same cycle: the pixel is consumed first, then the done is processed.
- DRAIN: when the FIFO is empty, go to DONE. DONE: assert frame_done for one cycle, then go to IDLE. Error flags hold until the next frame start.
- Handshake:
  - word_data and word_last are stable while word_valid=1 and word_ready=0.
  - A push and a pop in the same cycle on a full FIFO succeed; the pop frees the slot first.
  - A push and a pop in the same cycle on an empty FIFO: the word is visible the next cycle (no bypass).
- Counters wrap at their limits; row_idx saturates at IMG_H-1.

Test Plan:
- IMG_W=IMG_H=8, word_ready=1, frame pixels 0x00..0x3F with jump every 8 -> 16 words.
  - First word 0x03020100, last word 0x3F3E3D3C with word_last=1.
  - frame_done pulses once; all errors stay 0.
- Same frame with word_ready=0 for 20 cycles mid-frame -> err_overflow=1 once the FIFO is full.
  - Surviving words are in order, and held data is stable while stalled.
- Row 2 has only 6 pixels, then jump -> err_row_len=1.
  - A padded word 0x00000504-style (lanes 2,3 zero) is emitted, and row_idx advances.
- pix_done after 30 of 64 pixels -> err_frame_len=1.
  - Final word has 2 valid lanes, zero padding and word_last=1, and frame_done follows the FIFO drain.
- Assert rst=0 while 3 words are buffered -> word_valid=0 immediately and errors cleared.
  - The next frame starting with jump packs correctly.
- Two back-to-back frames -> frame_done pulses twice; errors from frame 1 are cleared at frame 2 start.
